// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited in-order I-cache requests and
// buffers {pc, inst} pairs in a FIFO; response visible next cycle, head held while out_stall.
module fetch_unit #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    QUEUE_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    output logic                  ic_req_valid,
    output logic [ADDR_WIDTH-1:0] ic_req_addr,
    input  logic                  ic_req_ready,
    input  logic                  ic_rsp_valid,
    input  logic [DATA_WIDTH-1:0] ic_rsp_data,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_inst,
    input  logic                  out_stall
);
    localparam int            CW    = $clog2(QUEUE_DEPTH + 1);
    localparam int            OW    = CW + 1;
    localparam int            PW    = $clog2(QUEUE_DEPTH);
    localparam logic [CW-1:0] C_ONE = CW'(1);
    localparam logic [PW-1:0] LAST  = PW'(QUEUE_DEPTH - 1);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         outst_q, outst_d;
    logic [CW-1:0]         drop_q, drop_d;
    logic [PW-1:0]         rd_q, rd_d, wr_q, wr_d;
    logic [PW-1:0]         ifl_rd_q, ifl_rd_d, ifl_wr_q, ifl_wr_d;

    logic [ADDR_WIDTH-1:0] fifo_pc   [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_inst [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] ifl_pc    [QUEUE_DEPTH];

    logic          credit, accept, rsp_ok, push, pop;
    logic [OW-1:0] occupancy;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    // Credit counts in-flight requests too, so a response always finds a free slot.
    assign occupancy    = {1'b0, outst_q} + {1'b0, count_q};
    assign credit       = occupancy < OW'(QUEUE_DEPTH);
    assign ic_req_valid = rst_n && !redirect_valid && credit;
    assign ic_req_addr  = pc_q;
    assign accept       = ic_req_valid && ic_req_ready;

    // A response with nothing outstanding is a protocol violation and is ignored.
    assign rsp_ok = ic_rsp_valid && (outst_q != '0);
    assign push   = rsp_ok && !redirect_valid && (drop_q == '0);
    assign pop    = out_valid && !out_stall && !redirect_valid;

    assign out_valid = (count_q != '0);
    assign out_pc    = out_valid ? fifo_pc[rd_q]   : '0;
    assign out_inst  = out_valid ? fifo_inst[rd_q] : '0;

    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        outst_d  = outst_q;
        drop_d   = drop_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        ifl_rd_d = ifl_rd_q;
        ifl_wr_d = ifl_wr_q;

        if (rsp_ok) begin
            ifl_rd_d = ptr_inc(ifl_rd_q);
            outst_d  = outst_q - C_ONE;
        end

        if (redirect_valid) begin
            // Everything still owed by the cache belongs to the abandoned stream.
            pc_d    = redirect_target;
            count_d = '0;
            rd_d    = '0;
            wr_d    = '0;
            drop_d  = outst_d;
        end else begin
            if (accept) begin
                pc_d     = pc_q + ADDR_WIDTH'(4);
                ifl_wr_d = ptr_inc(ifl_wr_q);
                outst_d  = outst_d + C_ONE;
            end
            if (rsp_ok && (drop_q != '0)) begin
                drop_d = drop_q - C_ONE;
            end
            if (push) begin
                wr_d = ptr_inc(wr_q);
            end
            if (pop) begin
                rd_d = ptr_inc(rd_q);
            end
            if (push && !pop) begin
                count_d = count_q + C_ONE;
            end else if (!push && pop) begin
                count_d = count_q - C_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            count_q  <= '0;
            outst_q  <= '0;
            drop_q   <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
            ifl_rd_q <= '0;
            ifl_wr_q <= '0;
        end else begin
            pc_q     <= pc_d;
            count_q  <= count_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            ifl_rd_q <= ifl_rd_d;
            ifl_wr_q <= ifl_wr_d;
        end
    end

    // Storage arrays need no reset; occupancy is tracked by the counters above.
    always_ff @(posedge clk) begin
        if (accept) begin
            ifl_pc[ifl_wr_q] <= pc_q;
        end
        if (push) begin
            fifo_pc[wr_q]   <= ifl_pc[ifl_rd_q];
            fifo_inst[wr_q] <= ic_rsp_data;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order cache model plus a queue-based reference of the fetch stream.
module tb_fetch_unit;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        ic_req_valid;
    logic [31:0] ic_req_addr;
    logic        ic_req_ready;
    logic        ic_rsp_valid;
    logic [31:0] ic_rsp_data;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_stall;

    always #5 clk = ~clk;

    fetch_unit #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .RESET_PC   (RST_PC),
        .QUEUE_DEPTH(DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .ic_req_valid   (ic_req_valid),
        .ic_req_addr    (ic_req_addr),
        .ic_req_ready   (ic_req_ready),
        .ic_rsp_valid   (ic_rsp_valid),
        .ic_rsp_data    (ic_rsp_data),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_stall      (out_stall)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          due;
        bit          doomed;
    } creq_t;

    creq_t       cq[$];      // requests accepted by the cache, oldest first
    logic [31:0] q_pc[$];    // expected FIFO contents
    logic [31:0] q_inst[$];
    logic [31:0] m_pc;
    int          cyc, lat, n_tests, n_fail;
    bit          obs_acc, obs_ov, obs_rv;
    logic [31:0] obs_addr, obs_opc;

    task automatic step(input bit redir, input logic [31:0] tgt, input bit stall, input bit rdy);
        bit          rsp, exp_rv, exp_ov;
        logic [31:0] exp_opc, exp_oi;
        creq_t       r;
        int          l;
        @(negedge clk);
        rsp = (cq.size() > 0) && (cq[0].due <= cyc);
        redirect_valid  = redir;
        redirect_target = tgt;
        out_stall       = stall;
        ic_req_ready    = rdy;
        ic_rsp_valid    = rsp;
        ic_rsp_data     = rsp ? cq[0].data : $urandom;
        #1;
        exp_rv  = !redir && ((cq.size() + q_pc.size()) < DEPTH);
        exp_ov  = (q_pc.size() != 0);
        exp_opc = 32'h0;
        exp_oi  = 32'h0;
        if (exp_ov) begin
            exp_opc = q_pc[0];
            exp_oi  = q_inst[0];
        end
        n_tests++;
        if (ic_req_valid !== exp_rv) begin
            n_fail++;
            $display("FAIL req_valid cyc=%0d: got %b expected %b", cyc, ic_req_valid, exp_rv);
        end
        n_tests++;
        if (exp_rv && (ic_req_addr !== m_pc)) begin
            n_fail++;
            $display("FAIL req_addr cyc=%0d: got %h expected %h", cyc, ic_req_addr, m_pc);
        end
        n_tests++;
        if (out_valid !== exp_ov) begin
            n_fail++;
            $display("FAIL out_valid cyc=%0d: got %b expected %b", cyc, out_valid, exp_ov);
        end
        n_tests++;
        if ((out_pc !== exp_opc) || (out_inst !== exp_oi)) begin
            n_fail++;
            $display("FAIL out_entry cyc=%0d: got %h/%h expected %h/%h", cyc, out_pc, out_inst, exp_opc, exp_oi);
        end
        obs_acc  = ic_req_valid && ic_req_ready;
        obs_rv   = ic_req_valid;
        obs_ov   = out_valid;
        obs_opc  = out_pc;
        obs_addr = ic_req_addr;

        if (rsp) r = cq.pop_front();
        if (redir) begin
            q_pc.delete();
            q_inst.delete();
            foreach (cq[i]) cq[i].doomed = 1'b1;
            m_pc = tgt;
        end else begin
            if (exp_ov && !stall) begin
                void'(q_pc.pop_front());
                void'(q_inst.pop_front());
            end
            if (rsp && !r.doomed) begin
                q_pc.push_back(r.addr);
                q_inst.push_back(r.data);
            end
            if (exp_rv && rdy) begin
                l = (lat == 0) ? int'($urandom_range(1, 4)) : lat;
                cq.push_back('{m_pc, $urandom, cyc + l, 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        ic_req_ready    = 1'b0;
        ic_rsp_valid    = 1'b0;
        ic_rsp_data     = 32'h0;
        out_stall       = 1'b0;
        q_pc.delete();
        q_inst.delete();
        cq.delete();
        m_pc = RST_PC;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ic_req_ready = 1'b1;
        redirect_valid = 1'b0;
        ic_rsp_valid = 1'b0;
        out_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ((ic_req_valid !== 1'b0) || (out_valid !== 1'b0)) begin
            n_fail++;
            $display("FAIL reset_valids: got req=%b out=%b expected 0/0", ic_req_valid, out_valid);
        end
        n_tests++;
        if ((out_pc !== 32'h0) || (out_inst !== 32'h0)) begin
            n_fail++;
            $display("FAIL reset_outs: got %h/%h expected 0/0", out_pc, out_inst);
        end
        do_reset();
    endtask

    task automatic test_startup();
        int first_acc, first_ov, n_ov;
        logic [31:0] first_pc;
        first_acc = -1;
        first_ov  = -1;
        first_pc  = 32'h0;
        n_ov      = 0;
        lat = 1;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b1);
            if (obs_acc && first_acc < 0) first_acc = cyc - 1;
            if (obs_ov && first_ov < 0) begin
                first_ov = cyc - 1;
                first_pc = obs_opc;
            end
            if (i >= 10 && obs_ov) n_ov++;
        end
        n_tests++;
        if ((first_ov - first_acc) != 2) begin
            n_fail++;
            $display("FAIL fetch_latency: got %0d expected 2", first_ov - first_acc);
        end
        n_tests++;
        if (first_pc !== RST_PC) begin
            n_fail++;
            $display("FAIL first_out_pc: got %h expected %h", first_pc, RST_PC);
        end
        n_tests++;
        if (n_ov != 20) begin
            n_fail++;
            $display("FAIL throughput: got %0d expected 20", n_ov);
        end
    endtask

    task automatic test_ready_low();
        logic [31:0] held;
        step(1'b0, 32'h0, 1'b0, 1'b0);
        held = obs_addr;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b0);
            n_tests++;
            if (obs_addr !== held) begin
                n_fail++;
                $display("FAIL ready_low_hold: got %h expected %h", obs_addr, held);
            end
        end
        repeat (10) step(1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic test_stall();
        int n_acc;
        do_reset();
        lat = 1;
        n_acc = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            if (obs_acc) n_acc++;
        end
        n_tests++;
        if (n_acc != DEPTH) begin
            n_fail++;
            $display("FAIL stall_accepts: got %0d expected %0d", n_acc, DEPTH);
        end
        n_tests++;
        if ((obs_rv !== 1'b0) || (obs_opc !== RST_PC)) begin
            n_fail++;
            $display("FAIL stall_hold: got req=%b pc=%h expected 0/%h", obs_rv, obs_opc, RST_PC);
        end
        repeat (20) step(1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic test_redirect_inflight();
        bit          seen;
        logic [31:0] pc_after;
        do_reset();
        lat = 3;
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 32'h400, 1'b0, 1'b1);
        seen = 1'b0;
        pc_after = 32'h0;
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b1);
            if (obs_ov && !seen) begin
                seen = 1'b1;
                pc_after = obs_opc;
            end
        end
        n_tests++;
        if (!seen || (pc_after !== 32'h400)) begin
            n_fail++;
            $display("FAIL redirect_first_pc: got %h (seen=%b) expected 00000400", pc_after, seen);
        end
    endtask

    task automatic test_redirect_same_cycle();
        bit found;
        do_reset();
        lat = 1;
        repeat (6) step(1'b0, 32'h0, 1'b0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if ((q_pc.size() > 0) && (cq.size() > 0) && (cq[0].due <= cyc)) begin
                step(1'b1, 32'h2000, 1'b0, 1'b1);
                found = 1'b1;
            end else begin
                step(1'b0, 32'h0, 1'b0, 1'b1);
            end
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL redirect_setup: got no rsp+pop cycle expected one within 10");
        end
        step(1'b0, 32'h0, 1'b0, 1'b1);
        n_tests++;
        if (obs_ov !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_flush: got out_valid=%b expected 0", obs_ov);
        end
        repeat (10) step(1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_midstream();
        do_reset();
        lat = 1;
        for (int i = 0; i < 12 && q_pc.size() != 3; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        @(posedge clk);
        #3;
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_pre: got out_valid=%b expected 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ((out_valid !== 1'b0) || (ic_req_valid !== 1'b0)) begin
            n_fail++;
            $display("FAIL midreset_async: got out=%b req=%b expected 0/0", out_valid, ic_req_valid);
        end
        do_reset();
        step(1'b0, 32'h0, 1'b0, 1'b1);
        n_tests++;
        if (!obs_acc || (obs_addr !== RST_PC)) begin
            n_fail++;
            $display("FAIL midreset_restart: got acc=%b addr=%h expected 1/%h", obs_acc, obs_addr, RST_PC);
        end
        repeat (10) step(1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        do_reset();
        lat = 0;
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 99) < 4, $urandom & 32'hFFFF_FFFC,
                 $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 75);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        lat     = 1;
        m_pc    = RST_PC;
        redirect_target = 32'h0;
        ic_rsp_data     = 32'h0;
        test_reset();
        test_startup();
        test_ready_low();
        test_stall();
        test_redirect_inflight();
        test_redirect_same_cycle();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the fetch-to-decode pipeline register. It owns the program counter, issues in-order fetch requests to the instruction cache with a ready/valid handshake, and buffers returned instructions in a small FIFO. It presents a PC/instruction pair that the downstream register captures when it is not stalled. Branch redirects from execute restart fetch at a new target and discard all older in-flight and buffered instructions.

## Interface
- `DATA_WIDTH`, 32: instruction width.
- `ADDR_WIDTH`, 32: PC width.
- `RESET_PC`, 0: PC value loaded at reset.
- `QUEUE_DEPTH`, 4: FIFO entries. Must be ≥2; 3 or more is needed for full throughput.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `redirect_valid` in 1: restart fetch this cycle.
- `redirect_target` in ADDR_WIDTH: new PC, word aligned.
- `ic_req_valid` out 1: fetch request.
- `ic_req_addr` out ADDR_WIDTH: address being fetched; equals the PC register.
- `ic_req_ready` in 1: cache accepts the request.
- `ic_rsp_valid` in 1: instruction returned. Responses arrive in request order, at least 1 cycle after acceptance.
- `ic_rsp_data` in DATA_WIDTH: returned instruction.
- `out_valid` out 1: FIFO head is valid.
- `out_pc` out ADDR_WIDTH: PC of the head entry.
- `out_inst` out DATA_WIDTH: instruction of the head entry.
- `out_stall` in 1: downstream stall; the head is held while this is high.

## Operation
- State:
  - `pc` register.
  - FIFO of {pc, inst} entries, with `count` in 0..QUEUE_DEPTH.
  - `outstanding` in 0..QUEUE_DEPTH: accepted requests not yet answered, counting doomed ones.
  - `drop` in 0..outstanding: responses still owed to the pre-redirect stream.
- Request:
  - `ic_req_valid = !redirect_valid && (outstanding + count < QUEUE_DEPTH)`. Use registered values only; a pop in the same cycle does not add credit.
  - On accept (`ic_req_valid && ic_req_ready`): `pc <= pc + 4` (wraps modulo 2^ADDR_WIDTH) and `outstanding` increments.
  - Each response's PC is captured by a parallel PC FIFO or an equivalent mechanism, so every returned instruction is paired with the address it was fetched from.
- Response with no redirect in the same cycle:
  - If `drop > 0`: discard the response and decrement `drop`.
  - Otherwise push {pc, inst}. There is always space because of the credit rule.
  - `outstanding` decrements in both cases.
- Pop: when `out_valid && !out_stall`, the head is removed.
- Redirect (`redirect_valid = 1`) takes priority over everything else:
  - `pc <= redirect_target`.
  - FIFO cleared.
  - No request issued that cycle.
  - Any response arriving that cycle is discarded.
  - `drop <= outstanding - ic_rsp_valid` and `outstanding <= outstanding - ic_rsp_valid`.
  - Any pop that cycle is moot.
- Outputs:
  - `out_valid = (count != 0)`.
  - `out_pc` and `out_inst` show the head entry, or 0 when the FIFO is empty.
- `ic_rsp_valid` with `outstanding == 0` is a protocol violation: ignore it and leave all state unchanged.

## Timing
- Reset values (asynchronous):
  - `pc = RESET_PC`.
  - `count`, `outstanding` and `drop` are 0.
  - `out_valid = 0`, `out_pc = 0`, `out_inst = 0`.
  - `ic_req_valid = 0` while `rst_n` is low.
- First request (addr `RESET_PC`) appears in the first cycle after `rst_n` rises.
- A response in cycle N is visible on `out_*` in cycle N+1.
- Fetch latency: request accept → `out_valid` is at least 2 cycles.
- Throughput: with a 1-cycle cache, no stalls and QUEUE_DEPTH ≥ 3, one instruction per cycle in steady state.
- After a redirect in cycle N:
  - The request for `redirect_target` appears in cycle N+1, provided credit is available.
  - Credit can be reduced until doomed responses drain.
- Stall held k cycles: `out_*` stays constant. Requests continue until `outstanding + count = QUEUE_DEPTH`, then `ic_req_valid` stays 0.
- Reset asserted mid-operation: all state is cleared immediately. Responses for pre-reset requests must not be sent by the cache.

## Test plan
- Reset release, `RESET_PC=0x100`, cache always ready with 1-cycle latency, no stall:
  - Requests 0x100, 0x104, 0x108, … on consecutive cycles.
  - `out_pc` 0x100 first valid 2 cycles after the first accept, then increments by 4 every cycle.
- Hold `out_stall=1` for 10 cycles with QUEUE_DEPTH=4:
  - Exactly 4 requests are accepted, then `ic_req_valid` stays 0.
  - `out_*` holds the 0x100 entry.
  - After release, entries drain in order and fetch resumes.
- Cache latency 3 and two requests in flight, then `redirect_valid` with target 0x400:
  - Both old responses are discarded and `drop` returns to 0.
  - The first `out_pc` after the redirect is 0x400.
- Redirect in the same cycle as a response and an unstalled pop:
  - The response is dropped, the FIFO is empty next cycle, and `outstanding` is decremented.
- `ic_req_ready=0` for 5 cycles:
  - `ic_req_addr` is held, `pc` is not incremented, and there are no duplicate pushes.
- Assert `rst_n=0` asynchronously mid-stream with the FIFO holding 3 entries:
  - `out_valid` drops immediately.
  - After release, the first request is again at `RESET_PC`.
